dcache_direct: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the execute/memory stage and DataMem.
- Serves loads (LB/LH/LW/LBU/LHU) from 8-byte lines.
- On a load miss, stalls the pipeline and refills a whole line from DataMem's 64-bit block read port.
- Stores always pass through to DataMem and update the line only on a hit.

---
 rtl/cache_pkg.sv | 50 +++++
 rtl/dcache_direct_if.sv | 32 +++
 rtl/load_extract.sv | 46 ++++
 rtl/dcache_direct.sv | 143 ++++++++++++++
 tb/tb_dcache_direct.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types, func3 codes and access-size helpers for the direct-mapped data cache.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } dc_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // RV32 load/store size codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int LINE_BYTES = 8;

    // Access width; unrecognised codes fall back to a single byte (LB behaviour).
    function automatic acc_size_t access_size(input logic [2:0] func3);
        case (func3)
            LW:      return SZ_WORD;
            LH, LHU: return SZ_HALF;
            default: return SZ_BYTE;
        endcase
    endfunction

    // Only LBU/LHU zero-extend; everything else sign-extends.
    function automatic logic is_signed_load(input logic [2:0] func3);
        return !(func3 == LBU || func3 == LHU);
    endfunction

    // True when the access spills past the end of its 8-byte line.
    function automatic logic crosses_line(input logic [2:0] func3, input logic [2:0] offset);
        case (access_size(func3))
            SZ_WORD: return offset > 3'd4;
            SZ_HALF: return offset == 3'd7;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dcache_direct_if.sv
// CPU-side and DataMem-side signals of the data cache, grouped as one bus.
interface dcache_direct_if #(
    parameter int DATA_WIDTH = 32
);
    // CPU side
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic [2:0]            cpu_func3;
    logic                  cpu_re;
    logic                  cpu_we;
    logic [DATA_WIDTH-1:0] cpu_wd;
    logic [DATA_WIDTH-1:0] cpu_rd;
    logic                  stall;
    // DataMem side
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [2:0]            mem_func3;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [63:0]           mem_block;

    // Cache view
    modport slave (
        input  cpu_addr, cpu_func3, cpu_re, cpu_we, cpu_wd, mem_rd, mem_block,
        output cpu_rd, stall, mem_addr, mem_func3, mem_we, mem_wd
    );

    // Pipeline + DataMem view
    modport master (
        output cpu_addr, cpu_func3, cpu_re, cpu_we, cpu_wd, mem_rd, mem_block,
        input  cpu_rd, stall, mem_addr, mem_func3, mem_we, mem_wd
    );
endinterface

// File: rtl/load_extract.sv
// Byte-lane logic for one 8-byte line: extracts and extends a load result,
// and produces the byte enables and lane-aligned data for a store merge.
module load_extract
    import cache_pkg::*;
(
    input  logic [63:0] line_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [7:0]  byte_en_o,
    output logic [63:0] wline_o
);

    logic [5:0]  bit_shift;
    logic [31:0] shifted;
    logic        sext;

    assign bit_shift = {offset_i, 3'b000};
    assign shifted   = 32'(line_i >> bit_shift);
    assign sext      = is_signed_load(func3_i);
    assign wline_o   = {32'b0, wdata_i} << bit_shift;

    // Select the addressed lanes, extend the result and build the store byte mask.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        rdata_o   = '0;
        byte_en_o = 8'h01;
        case (access_size(func3_i))
            SZ_WORD: begin
                rdata_o   = shifted;
                byte_en_o = 8'h0F;
            end
            SZ_HALF: begin
                rdata_o   = {{16{sext & shifted[15]}}, shifted[15:0]};
                byte_en_o = 8'h03;
            end
            default: begin
                rdata_o   = {{24{sext & shifted[7]}}, shifted[7:0]};
                byte_en_o = 8'h01;
            end
        endcase
        byte_en_o = byte_en_o << offset_i;
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with 8-byte lines.
// Load misses stall for exactly two cycles (lookup + FILL) and refill a whole line.
module dcache_direct
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 16
) (
    input  logic             clk,
    input  logic             rst,
    dcache_direct_if.slave   bus,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 3;

    // Address split
    logic [2:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;

    assign offset = bus.cpu_addr[2:0];
    assign index  = bus.cpu_addr[IDX_W+2:3];
    assign tag    = bus.cpu_addr[DATA_WIDTH-1:IDX_W+3];

    // State and storage
    dc_state_t         state_q;
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NUM_SETS];
    logic [63:0]       data_q [NUM_SETS];
    logic [31:0]       hit_count_q;
    logic [31:0]       miss_count_q;

    // Lookup and request decode
    logic        in_idle;
    logic        is_load;
    logic        crossing;
    logic        hit;
    logic        load_hit;
    logic        load_miss;
    logic        store_fire;
    logic        store_upd;
    logic [63:0] line_rd;
    logic [31:0] ext_rd;
    logic [7:0]  byte_en;
    logic [63:0] wline;
    logic [63:0] merged_line;

    assign in_idle    = (state_q == IDLE);
    assign is_load    = bus.cpu_re & ~bus.cpu_we;
    assign crossing   = crosses_line(bus.cpu_func3, offset);
    assign hit        = valid_q[index] && (tag_q[index] == tag);
    assign load_hit   = in_idle & is_load & ~crossing & hit;
    assign load_miss  = in_idle & is_load & ~crossing & ~hit;
    assign store_fire = ~rst & in_idle & bus.cpu_we;
    assign store_upd  = store_fire & ~crossing & hit;
    assign line_rd    = data_q[index];

    load_extract u_extract (
        .line_i    (line_rd),
        .offset_i  (offset),
        .func3_i   (bus.cpu_func3),
        .wdata_i   (bus.cpu_wd),
        .rdata_o   (ext_rd),
        .byte_en_o (byte_en),
        .wline_o   (wline)
    );

    // Merge the store lanes into the resident line.
    always_comb begin
        merged_line = line_rd;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (byte_en[b]) begin
                merged_line[8*b +: 8] = wline[8*b +: 8];
            end
        end
    end

    // Write-through: stores go straight to DataMem; FILL suppresses writes.
    assign bus.mem_addr  = bus.cpu_addr;
    assign bus.mem_func3 = bus.cpu_func3;
    assign bus.mem_wd    = bus.cpu_wd;
    assign bus.mem_we    = store_fire;

    // Stall on the lookup cycle of a miss and throughout FILL; reset drops it at once.
    assign bus.stall = ~rst & ((state_q == FILL) | load_miss);

    // Load result: bypass for line-crossing loads, line data on a hit, zero otherwise.
    always_comb begin
        bus.cpu_rd = '0;
        if (!rst && is_load) begin
            if (crossing) begin
                bus.cpu_rd = bus.mem_rd;
            end else if (hit) begin
                bus.cpu_rd = ext_rd;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Controller: IDLE/FILL sequencing, valid bits and hit/miss counters.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_miss) begin
                        miss_count_q <= miss_count_q + 32'd1;
                        state_q      <= FILL;
                    end else if (load_hit) begin
                        hit_count_q  <= hit_count_q + 32'd1;
                    end
                end
                FILL: begin
                    valid_q[index] <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and line storage: refill in FILL, byte merge on a store hit.
    // NOTE: tag/data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (state_q == FILL) begin
            data_q[index] <= bus.mem_block;
            tag_q[index]  <= tag;
        end else if (store_upd) begin
            data_q[index] <= merged_line;
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct with a small byte-addressed DataMem model.
module tb_dcache_direct;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dcache_direct_if #(.DATA_WIDTH(32)) bus ();

    dcache_direct #(.DATA_WIDTH(32), .NUM_SETS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // DataMem model: 256 bytes indexed by address bits [7:0]
    logic [7:0] dmem [0:255];
    logic [7:0] ma;
    logic [7:0] mbase;

    always_comb begin
        ma          = bus.mem_addr[7:0];
        mbase       = {ma[7:3], 3'b000};
        bus.mem_rd  = {dmem[ma + 8'd3], dmem[ma + 8'd2], dmem[ma + 8'd1], dmem[ma]};
        bus.mem_block = '0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_block[8*i +: 8] = dmem[mbase + 8'(i)];
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            dmem[ma] <= bus.mem_wd[7:0];
            if (bus.mem_func3[1:0] != 2'b00) dmem[ma + 8'd1] <= bus.mem_wd[15:8];
            if (bus.mem_func3[1:0] == 2'b10) begin
                dmem[ma + 8'd2] <= bus.mem_wd[23:16];
                dmem[ma + 8'd3] <= bus.mem_wd[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
        bus.cpu_re    = re;
        bus.cpu_we    = we;
        bus.cpu_func3 = f3;
        bus.cpu_addr  = addr;
        bus.cpu_wd    = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle hit load: check result and no stall, then clock it.
    task automatic hit_load(input string tag, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] exp);
        req(1'b1, 1'b0, f3, addr, 32'h0);
        @(negedge clk);
        check({tag, "_stall"}, 32'(bus.stall), 32'd0);
        check({tag, "_rd"}, bus.cpu_rd, exp);
        next_cycle();
    endtask

    // Missing load held across the two stall cycles, checked on the hit cycle.
    task automatic miss_load(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp, input logic [31:0] exp_miss);
        req(1'b1, 1'b0, LW, addr, 32'h0);
        @(negedge clk);
        check({tag, "_stall_lookup"}, 32'(bus.stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check({tag, "_stall_fill"}, 32'(bus.stall), 32'd1);
        check({tag, "_mem_we_fill"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_miss_count"}, miss_count, exp_miss);
        next_cycle();
        @(negedge clk);
        check({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
        check({tag, "_rd"}, bus.cpu_rd, exp);
        next_cycle();
    endtask

    task automatic store(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req(1'b0, 1'b1, f3, addr, wd);
        @(negedge clk);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd1);
        check({tag, "_mem_wd"}, bus.mem_wd, wd);
        check({tag, "_mem_addr"}, bus.mem_addr, addr);
        check({tag, "_stall"}, 32'(bus.stall), 32'd0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        // 0x10000: 3F 7F FF 00 80 11 22 33
        dmem[0] = 8'h3F; dmem[1] = 8'h7F; dmem[2] = 8'hFF; dmem[3] = 8'h00;
        dmem[4] = 8'h80; dmem[5] = 8'h11; dmem[6] = 8'h22; dmem[7] = 8'h33;
        // 0x10010: 44 55 66 77
        dmem[16] = 8'h44; dmem[17] = 8'h55; dmem[18] = 8'h66; dmem[19] = 8'h77;
        // 0x10080: 01 02 03 04 05 06 07 08
        for (int i = 0; i < 8; i++) dmem[128 + i] = 8'(i + 1);

        // Reset with a pending load: outputs must stay quiet
        rst = 1'b1;
        req(1'b1, 1'b0, LW, 32'h0001_0000, 32'h0);
        @(negedge clk);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_cpu_rd", bus.cpu_rd, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        req(1'b0, 1'b0, LW, 32'h0001_0000, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // Idle cycle: no stall, counters held
        @(negedge clk);
        check("idle_stall", 32'(bus.stall), 32'd0);
        check("idle_hit_count", hit_count, 32'd0);
        next_cycle();

        // Cold LW miss, then hit on the post-fill cycle
        miss_load("cold_lw", 32'h0001_0000, 32'h00FF_7F3F, 32'd1);
        check("cold_hit_count", hit_count, 32'd1);
        hit_load("repeat_lw", LW, 32'h0001_0000, 32'h00FF_7F3F);
        check("repeat_hit_count", hit_count, 32'd2);
        check("repeat_miss_count", miss_count, 32'd1);

        // Byte loads with sign/zero extension
        hit_load("lb", LB, 32'h0001_0004, 32'hFFFF_FF80);
        hit_load("lbu", LBU, 32'h0001_0004, 32'h0000_0080);

        // Store hit updates the line; mem_we is a one-cycle pulse
        store("sw_hit", SW, 32'h0001_0000, 32'hDEAD_BEEF);
        req(1'b0, 1'b0, LW, 32'h0001_0000, 32'h0);
        @(negedge clk);
        check("sw_we_pulse_end", 32'(bus.mem_we), 32'd0);
        next_cycle();
        hit_load("lh_after_sw", LH, 32'h0001_0002, 32'hFFFF_DEAD);
        hit_load("lhu_after_sw", LHU, 32'h0001_0002, 32'h0000_DEAD);
        store("sb_hit", SB, 32'h0001_0005, 32'h0000_00AB);
        hit_load("lw_after_sb", LW, 32'h0001_0004, 32'h3322_AB80);
        check("store_hit_count", hit_count, 32'd7);

        // Line-crossing load bypasses the cache
        hit_load("cross_lw", LW, 32'h0001_0006, 32'h0000_3322);
        check("cross_hit_count", hit_count, 32'd7);
        check("cross_miss_count", miss_count, 32'd1);

        // Line-crossing store reaches memory only
        store("cross_sw", SW, 32'h0001_0006, 32'h1234_5678);
        hit_load("line_after_cross_sw", LW, 32'h0001_0004, 32'h3322_AB80);
        hit_load("mem_after_cross_sw", LW, 32'h0001_0007, 32'h0012_3456);

        // Conflict eviction on index 0
        miss_load("conflict_a", 32'h0001_0080, 32'h0403_0201, 32'd2);
        miss_load("conflict_b", 32'h0001_0000, 32'hDEAD_BEEF, 32'd3);
        check("conflict_hit_count", hit_count, 32'd10);

        // Store miss does not allocate
        store("sw_miss", SW, 32'h0001_0080, 32'hCAFE_F00D);
        miss_load("after_sw_miss", 32'h0001_0080, 32'hCAFE_F00D, 32'd4);
        check("after_sw_miss_hits", hit_count, 32'd11);

        // Reset during FILL discards the partial fill
        req(1'b1, 1'b0, LW, 32'h0001_0010, 32'h0);
        @(negedge clk);
        check("rstfill_lookup_stall", 32'(bus.stall), 32'd1);
        next_cycle();
        #2;
        check("rstfill_fill_stall", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rstfill_stall_async", 32'(bus.stall), 32'd0);
        check("rstfill_miss_count", miss_count, 32'd0);
        check("rstfill_hit_count", hit_count, 32'd0);
        req(1'b0, 1'b0, LW, 32'h0001_0010, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        miss_load("refill", 32'h0001_0010, 32'h7766_5544, 32'd1);
        req(1'b0, 1'b0, LW, 32'h0001_0010, 32'h0);
        @(negedge clk);
        check("refill_hit_count", hit_count, 32'd1);
        check("refill_miss_count", miss_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
